// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and a start/run/halt FSM.
// Zero-cycle memory read; stall holds PC and IF/ID, redirects override stall and halt.
module fetch_unit #(
   parameter int          LAST_ADDR = 55,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPC  = 6'b111111
) (
   input  logic        reloj,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [5:0]  branch_target,
   input  logic        jump,
   input  logic [5:0]  jump_target,
   input  logic [31:0] inst_data,
   output logic [5:0]  inst_addr,
   output logic [31:0] instr_out,
   output logic [5:0]  pc_plus1,
   output logic        valid,
   output logic        halted,
   output logic        addr_err
);

   localparam logic [5:0] LAST = 6'(LAST_ADDR);

   typedef enum logic [1:0] {
      ARRANQUE,
      CORRIENDO,
      DETENIDO
   } state_t;

   state_t      state_q;
   logic [5:0]  pc_q;
   logic [5:0]  pc_plus1_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic        halted_q;
   logic        addr_err_q;

   logic [5:0]  pc_seq_d;
   logic [5:0]  redir_tgt_d;
   logic        redir_d;
   logic        redir_bad_d;
   logic        is_halt_d;

   // Branch outranks jump; an out-of-range target falls back to address 0.
   always_comb begin
      pc_seq_d    = (pc_q == LAST) ? 6'd0 : pc_q + 6'd1;
      redir_d     = branch_taken | jump;
      redir_tgt_d = branch_taken ? branch_target : jump_target;
      redir_bad_d = redir_d && (redir_tgt_d > LAST);
      is_halt_d   = (inst_data[31:26] == HALT_OPC);
   end

   always_ff @(posedge reloj or negedge reset) begin
      if (!reset) begin
         state_q    <= ARRANQUE;
         pc_q       <= 6'd0;
         pc_plus1_q <= 6'd0;
         instr_q    <= NOP_WORD;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         case (state_q)
            ARRANQUE: begin
               pc_q    <= 6'd0;
               instr_q <= NOP_WORD;
               valid_q <= 1'b0;
               state_q <= CORRIENDO;
            end
            CORRIENDO: begin
               if (redir_d) begin
                  pc_q    <= redir_bad_d ? 6'd0 : redir_tgt_d;
                  instr_q <= NOP_WORD;
                  valid_q <= 1'b0;
                  if (redir_bad_d) begin
                     addr_err_q <= 1'b1;
                  end
               end else if (!stall) begin
                  instr_q    <= inst_data;
                  pc_plus1_q <= pc_seq_d;
                  valid_q    <= 1'b1;
                  // A latched halt word freezes the PC on its own address.
                  if (is_halt_d) begin
                     state_q  <= DETENIDO;
                     halted_q <= 1'b1;
                  end else begin
                     pc_q <= pc_seq_d;
                  end
               end
            end
            DETENIDO: begin
               instr_q <= NOP_WORD;
               valid_q <= 1'b0;
            end
            default: begin
               state_q <= ARRANQUE;
            end
         endcase
      end
   end

   assign inst_addr = pc_q;
   assign instr_out = instr_q;
   assign pc_plus1  = pc_plus1_q;
   assign valid     = valid_q;
   assign halted    = halted_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model k -> 32'h100+k, expected fetches queued and compared on output.
module tb_fetch_unit;

   logic        reloj;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [5:0]  branch_target;
   logic        jump;
   logic [5:0]  jump_target;
   logic [31:0] inst_data;
   logic [5:0]  inst_addr;
   logic [31:0] instr_out;
   logic [5:0]  pc_plus1;
   logic        valid;
   logic        halted;
   logic        addr_err;

   typedef struct packed {
      logic [31:0] w;
      logic [5:0]  p;
   } exp_t;

   logic [31:0] mem [64];
   exp_t        sb [$];
   logic [5:0]  m_pc;
   int          checks;
   int          failures;

   fetch_unit dut (
      .reloj        (reloj),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .inst_data    (inst_data),
      .inst_addr    (inst_addr),
      .instr_out    (instr_out),
      .pc_plus1     (pc_plus1),
      .valid        (valid),
      .halted       (halted),
      .addr_err     (addr_err)
   );

   assign inst_data = mem[inst_addr];

   initial begin
      reloj = 1'b0;
      forever #5 reloj = ~reloj;
   end

   function automatic logic [5:0] nxt(input logic [5:0] a);
      return (a == 6'd55) ? 6'd0 : a + 6'd1;
   endfunction

   task automatic step();
      @(posedge reloj);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      step();
      m_pc = 6'd0;
      sb.delete();
   endtask

   // Sequential fetches: queue the expected word, clock, then compare against the queue head.
   task automatic fetch_n(input int n, input string tag);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.w = mem[m_pc];
         e.p = nxt(m_pc);
         sb.push_back(e);
         step();
         m_pc = nxt(m_pc);
         checks++;
         if (valid !== 1'b1) begin
            failures++;
            $display("FAIL %s valid got %b exp 1 (i=%0d)", tag, valid, i);
         end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty got instr %h exp queued word", tag, instr_out);
         end else begin
            e = sb.pop_front();
            if (instr_out !== e.w || pc_plus1 !== e.p) begin
               failures++;
               $display("FAIL %s instr/pc_plus1 got %h/%0d exp %h/%0d (i=%0d)",
                        tag, instr_out, pc_plus1, e.w, e.p, i);
            end
         end
         checks++;
         if (inst_addr !== m_pc) begin
            failures++;
            $display("FAIL %s inst_addr got %0d exp %0d", tag, inst_addr, m_pc);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (inst_addr !== 6'd0 || instr_out !== 32'h0 || pc_plus1 !== 6'd0 ||
          valid !== 1'b0 || halted !== 1'b0 || addr_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_async got addr=%0d instr=%h pcp1=%0d v=%b h=%b e=%b exp 0/0/0/0/0/0",
                  inst_addr, instr_out, pc_plus1, valid, halted, addr_err);
      end
      step();
      reset = 1'b1;
      step();
      checks++;
      if (valid !== 1'b0 || inst_addr !== 6'd0 || instr_out !== 32'h0) begin
         failures++;
         $display("FAIL reset_arranque got v=%b addr=%0d instr=%h exp 0/0/0", valid, inst_addr, instr_out);
      end
      m_pc = 6'd0;
      sb.delete();
      fetch_n(3, "first_fetch");
   endtask

   task automatic test_wrap();
      do_reset();
      fetch_n(58, "wrap");
   endtask

   task automatic test_stall();
      do_reset();
      fetch_n(4, "pre_stall");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (inst_addr !== 6'd4 || instr_out !== 32'h103 || valid !== 1'b1 || pc_plus1 !== 6'd4) begin
            failures++;
            $display("FAIL stall_hold got addr=%0d instr=%h v=%b pcp1=%0d exp 4/00000103/1/4",
                     inst_addr, instr_out, valid, pc_plus1);
         end
      end
      stall = 1'b0;
      fetch_n(1, "stall_resume");
      stall = 1'b1;
      reset = 1'b0;
      #1;
      checks++;
      if (inst_addr !== 6'd0 || instr_out !== 32'h0 || pc_plus1 !== 6'd0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_stall got addr=%0d instr=%h pcp1=%0d v=%b exp 0/0/0/0",
                  inst_addr, instr_out, pc_plus1, valid);
      end
      reset = 1'b1;
      stall = 1'b0;
   endtask

   task automatic test_redirect();
      do_reset();
      fetch_n(2, "pre_redir");
      branch_taken = 1'b1;
      branch_target = 6'd20;
      jump = 1'b1;
      jump_target = 6'd9;
      stall = 1'b1;
      step();
      checks++;
      if (inst_addr !== 6'd20 || valid !== 1'b0 || instr_out !== 32'h0 || pc_plus1 !== 6'd2) begin
         failures++;
         $display("FAIL branch_prio got addr=%0d v=%b instr=%h pcp1=%0d exp 20/0/0/2",
                  inst_addr, valid, instr_out, pc_plus1);
      end
      branch_taken = 1'b0;
      jump = 1'b0;
      stall = 1'b0;
      m_pc = 6'd20;
      fetch_n(1, "after_branch");
      jump = 1'b1;
      jump_target = 6'd9;
      step();
      checks++;
      if (inst_addr !== 6'd9 || valid !== 1'b0 || pc_plus1 !== 6'd21) begin
         failures++;
         $display("FAIL jump got addr=%0d v=%b pcp1=%0d exp 9/0/21", inst_addr, valid, pc_plus1);
      end
      m_pc = 6'd9;
      jump = 1'b0;
      fetch_n(1, "after_jump");
      jump = 1'b1;
      jump_target = 6'd55;
      step();
      checks++;
      if (inst_addr !== 6'd55 || addr_err !== 1'b0) begin
         failures++;
         $display("FAIL jump_last got addr=%0d err=%b exp 55/0", inst_addr, addr_err);
      end
      jump = 1'b0;
      m_pc = 6'd55;
      fetch_n(2, "last_wrap");
   endtask

   task automatic test_addr_err();
      do_reset();
      fetch_n(1, "pre_err");
      jump = 1'b1;
      jump_target = 6'd60;
      step();
      checks++;
      if (inst_addr !== 6'd0 || addr_err !== 1'b1 || valid !== 1'b0) begin
         failures++;
         $display("FAIL jump_oor got addr=%0d err=%b v=%b exp 0/1/0", inst_addr, addr_err, valid);
      end
      jump = 1'b0;
      m_pc = 6'd0;
      fetch_n(3, "err_run");
      checks++;
      if (addr_err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky got %b exp 1", addr_err);
      end
      branch_taken = 1'b1;
      branch_target = 6'd56;
      step();
      checks++;
      if (inst_addr !== 6'd0 || addr_err !== 1'b1) begin
         failures++;
         $display("FAIL branch_56 got addr=%0d err=%b exp 0/1", inst_addr, addr_err);
      end
      branch_taken = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (addr_err !== 1'b0) begin
         failures++;
         $display("FAIL err_clear got %b exp 0", addr_err);
      end
      reset = 1'b1;
   endtask

   task automatic test_halt();
      exp_t e;
      mem[7] = 32'hFC00_0000;
      do_reset();
      fetch_n(7, "pre_halt");
      stall = 1'b1;
      step();
      checks++;
      if (halted !== 1'b0 || inst_addr !== 6'd7 || instr_out !== 32'h106) begin
         failures++;
         $display("FAIL halt_stall got h=%b addr=%0d instr=%h exp 0/7/00000106", halted, inst_addr, instr_out);
      end
      stall = 1'b0;
      jump = 1'b1;
      jump_target = 6'd7;
      step();
      checks++;
      if (halted !== 1'b0 || inst_addr !== 6'd7 || valid !== 1'b0) begin
         failures++;
         $display("FAIL halt_redir got h=%b addr=%0d v=%b exp 0/7/0", halted, inst_addr, valid);
      end
      jump = 1'b0;
      e.w = mem[7];
      e.p = 6'd8;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++;
      if (instr_out !== e.w || valid !== 1'b1 || halted !== 1'b1 || inst_addr !== 6'd7 || pc_plus1 !== e.p) begin
         failures++;
         $display("FAIL halt_latch got instr=%h v=%b h=%b addr=%0d pcp1=%0d exp %h/1/1/7/%0d",
                  instr_out, valid, halted, inst_addr, pc_plus1, e.w, e.p);
      end
      step();
      checks++;
      if (instr_out !== 32'h0 || valid !== 1'b0 || halted !== 1'b1 || inst_addr !== 6'd7) begin
         failures++;
         $display("FAIL halt_bubble got instr=%h v=%b h=%b addr=%0d exp 0/0/1/7", instr_out, valid, halted, inst_addr);
      end
      branch_taken = 1'b1;
      branch_target = 6'd3;
      jump = 1'b1;
      jump_target = 6'd60;
      step();
      step();
      checks++;
      if (inst_addr !== 6'd7 || halted !== 1'b1 || valid !== 1'b0 || addr_err !== 1'b0) begin
         failures++;
         $display("FAIL halt_frozen got addr=%0d h=%b v=%b e=%b exp 7/1/0/0", inst_addr, halted, valid, addr_err);
      end
      branch_taken = 1'b0;
      jump = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (inst_addr !== 6'd0 || instr_out !== 32'h0 || pc_plus1 !== 6'd0 ||
          valid !== 1'b0 || halted !== 1'b0 || addr_err !== 1'b0) begin
         failures++;
         $display("FAIL halt_reset got addr=%0d instr=%h pcp1=%0d v=%b h=%b e=%b exp 0/0/0/0/0/0",
                  inst_addr, instr_out, pc_plus1, valid, halted, addr_err);
      end
      reset = 1'b1;
      mem[7] = 32'h107;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = 6'd0;
      jump = 1'b0;
      jump_target = 6'd0;
      reset = 1'b1;
      m_pc = 6'd0;
      for (int k = 0; k < 64; k++) begin
         mem[k] = 32'h100 + k;
      end
      test_reset();
      test_wrap();
      test_stall();
      test_redirect();
      test_addr_err();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
